// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: fetch-stage constants, fetch state encoding and
// the fetch-to-decode bundle.
package cpu_pkg;

    localparam int              PC_W     = 32;
    localparam logic [PC_W-1:0] RESET_PC = '0;
    localparam int              PC_STEP  = 1;
    localparam logic [PC_W-1:0] NOP_INSN = 32'h0000_0000;

    typedef enum logic {
        EMPTY = 1'b0,
        VALID = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] insn;
        logic            valid;
    } fetch_out_t;

endpackage

// File: rtl/pc_reg.sv
// Program-counter register with synchronous clear, enable and load value.
module pc_reg #(
    parameter int         W         = 32,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous imem address,
// squashes wrong-path fetches on redirect and holds under stall.
module fetch_stage #(
    parameter int              PC_W     = cpu_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter int              PC_STEP  = cpu_pkg::PC_STEP,
    parameter logic [PC_W-1:0] NOP_INSN = cpu_pkg::NOP_INSN
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            stall,
    input  logic            redirect_en,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] imem_addr,
    input  logic [PC_W-1:0] imem_data,
    output logic [PC_W-1:0] fd_pc,
    output logic [PC_W-1:0] fd_insn,
    output logic            fd_en,
    output logic            fd_valid
);

    import cpu_pkg::*;

    localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] fetch_pc_q;
    logic            pc_en;
    fetch_state_t    state_q;
    fetch_state_t    state_d;

    // A redirect overrides a simultaneous stall; otherwise a stall freezes both PCs.
    assign pc_en = redirect_en | ~stall;
    assign pc_d  = redirect_en ? redirect_pc : pc_q + STEP;

    pc_reg #(
        .W         (PC_W),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk (clk),
        .clr (clr),
        .en  (pc_en),
        .d   (pc_d),
        .q   (pc_q)
    );

    pc_reg #(
        .W         (PC_W),
        .RESET_VAL (RESET_PC)
    ) u_fetch_pc (
        .clk (clk),
        .clr (clr),
        .en  (pc_en),
        .d   (pc_q),
        .q   (fetch_pc_q)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (redirect_en) begin
            state_d = EMPTY;
        end else if (!stall) begin
            state_d = VALID;
        end
    end

    // Under stall the displayed address is re-issued so imem_data stays stable.
    assign imem_addr = (stall && !redirect_en) ? fetch_pc_q : pc_q;
    assign fd_valid  = (state_q == VALID) && !redirect_en;
    assign fd_insn   = fd_valid ? imem_data : NOP_INSN;
    assign fd_pc     = fetch_pc_q + STEP;
    assign fd_en     = !stall || redirect_en;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stimulus against a cycle-level behavioural model of the fetch stream.
module tb_fetch_stage;

    typedef logic [97:0] obs_t;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] fd_pc;
    logic [31:0] fd_insn;
    logic        fd_en;
    logic        fd_valid;

    int   checks = 0;
    int   passed = 0;
    obs_t obs;
    obs_t exp;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return 32'h1000 + a;
    endfunction

    // Synchronous instruction memory: data for last cycle's address.
    always @(posedge clk) imem_data <= mem_f(imem_addr);

    fetch_stage dut (
        .clk         (clk),
        .clr         (clr),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .fd_pc       (fd_pc),
        .fd_insn     (fd_insn),
        .fd_en       (fd_en),
        .fd_valid    (fd_valid)
    );

    assign obs = {imem_addr, fd_pc, fd_insn, fd_valid, fd_en};

    function automatic obs_t pack(input logic [31:0] a, input logic [31:0] p,
                                  input logic [31:0] i, input logic v, input logic e);
        return {a, p, i, v, e};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("addr=%h fd_pc=%h insn=%h valid=%b en=%b",
                         o[97:66], o[65:34], o[33:2], o[1], o[0]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input bit c, input bit s, input bit r, input logic [31:0] t);
        clr         = c;
        stall       = s;
        redirect_en = r;
        redirect_pc = t;
        #1;
    endtask

    task automatic test_reset();
        tick();
        apply(1, 0, 0, 32'h0);
        exp = pack(32'h0, 32'h1, 32'h0, 1'b0, 1'b1);
        checks++;
        if (obs !== exp) $display("FAIL reset_hold: got %s want %s", fmt(obs), fmt(exp));
        else passed++;
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, 32'h0);
            if (i == 0) exp = pack(32'h0, 32'h1, 32'h0, 1'b0, 1'b1);
            else        exp = pack(32'(i), 32'(i), 32'h1000 + 32'(i - 1), 1'b1, 1'b1);
            checks++;
            if (obs !== exp) $display("FAIL reset_start[%0d]: got %s want %s", i, fmt(obs), fmt(exp));
            else passed++;
            tick();
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            apply(0, 0, 0, 32'h0);
            exp = pack(32'h4 + 32'(i), 32'h4 + 32'(i), 32'h1003 + 32'(i), 1'b1, 1'b1);
            checks++;
            if (obs !== exp) $display("FAIL stall_approach[%0d]: got %s want %s", i, fmt(obs), fmt(exp));
            else passed++;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, 0, 32'h0);
            exp = pack(32'h5, 32'h6, 32'h1005, 1'b1, 1'b0);
            checks++;
            if (obs !== exp) $display("FAIL stall_hold[%0d]: got %s want %s", i, fmt(obs), fmt(exp));
            else passed++;
            tick();
        end
        apply(0, 0, 0, 32'h0);
        exp = pack(32'h6, 32'h6, 32'h1005, 1'b1, 1'b1);
        checks++;
        if (obs !== exp) $display("FAIL stall_release: got %s want %s", fmt(obs), fmt(exp));
        else passed++;
        tick();
        apply(0, 0, 0, 32'h0);
        exp = pack(32'h7, 32'h7, 32'h1006, 1'b1, 1'b1);
        checks++;
        if (obs !== exp) $display("FAIL stall_resume: got %s want %s", fmt(obs), fmt(exp));
        else passed++;
    endtask

    task automatic test_redirect();
        apply(0, 0, 1, 32'h40);
        exp = pack(32'h7, 32'h7, 32'h0, 1'b0, 1'b1);
        checks++;
        if (obs !== exp) $display("FAIL redirect_cycle: got %s want %s", fmt(obs), fmt(exp));
        else passed++;
        tick();
        apply(0, 0, 0, 32'h0);
        exp = pack(32'h40, 32'h8, 32'h0, 1'b0, 1'b1);
        checks++;
        if (obs !== exp) $display("FAIL redirect_bubble: got %s want %s", fmt(obs), fmt(exp));
        else passed++;
        tick();
        apply(0, 0, 0, 32'h0);
        exp = pack(32'h41, 32'h41, 32'h1040, 1'b1, 1'b1);
        checks++;
        if (obs !== exp) $display("FAIL redirect_target: got %s want %s", fmt(obs), fmt(exp));
        else passed++;
        tick();
    endtask

    task automatic test_redirect_stall();
        apply(0, 1, 1, 32'h80);
        exp = pack(32'h42, 32'h42, 32'h0, 1'b0, 1'b1);
        checks++;
        if (obs !== exp) $display("FAIL redir_stall_cycle: got %s want %s", fmt(obs), fmt(exp));
        else passed++;
        tick();
        apply(0, 0, 0, 32'h0);
        exp = pack(32'h80, 32'h43, 32'h0, 1'b0, 1'b1);
        checks++;
        if (obs !== exp) $display("FAIL redir_stall_bubble: got %s want %s", fmt(obs), fmt(exp));
        else passed++;
        tick();
        apply(0, 0, 0, 32'h0);
        exp = pack(32'h81, 32'h81, 32'h1080, 1'b1, 1'b1);
        checks++;
        if (obs !== exp) $display("FAIL redir_stall_target: got %s want %s", fmt(obs), fmt(exp));
        else passed++;
        tick();
    endtask

    task automatic test_wrap();
        apply(0, 0, 1, 32'hFFFF_FFFF);
        exp = pack(32'h82, 32'h82, 32'h0, 1'b0, 1'b1);
        checks++;
        if (obs !== exp) $display("FAIL wrap_redirect: got %s want %s", fmt(obs), fmt(exp));
        else passed++;
        tick();
        apply(0, 0, 0, 32'h0);
        exp = pack(32'hFFFF_FFFF, 32'h83, 32'h0, 1'b0, 1'b1);
        checks++;
        if (obs !== exp) $display("FAIL wrap_issue_top: got %s want %s", fmt(obs), fmt(exp));
        else passed++;
        tick();
        apply(0, 0, 0, 32'h0);
        exp = pack(32'h0, 32'h0, 32'h0000_0FFF, 1'b1, 1'b1);
        checks++;
        if (obs !== exp) $display("FAIL wrap_rollover: got %s want %s", fmt(obs), fmt(exp));
        else passed++;
        tick();
        apply(0, 0, 0, 32'h0);
        exp = pack(32'h1, 32'h1, 32'h1000, 1'b1, 1'b1);
        checks++;
        if (obs !== exp) $display("FAIL wrap_continue: got %s want %s", fmt(obs), fmt(exp));
        else passed++;
        tick();
    endtask

    task automatic test_clr_mid(input bit during_redirect);
        if (during_redirect) begin
            apply(1, 0, 1, 32'h55);
            exp = pack(32'h3, 32'h3, 32'h0, 1'b0, 1'b1);
        end else begin
            apply(1, 1, 0, 32'h0);
            exp = pack(32'h1, 32'h2, 32'h1001, 1'b1, 1'b0);
        end
        checks++;
        if (obs !== exp) $display("FAIL clr_mid_%0d_pre: got %s want %s", during_redirect, fmt(obs), fmt(exp));
        else passed++;
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 32'h0);
            if (i == 0) exp = pack(32'h0, 32'h1, 32'h0, 1'b0, 1'b1);
            else        exp = pack(32'(i), 32'(i), 32'h1000 + 32'(i - 1), 1'b1, 1'b1);
            checks++;
            if (obs !== exp) $display("FAIL clr_mid_%0d_start[%0d]: got %s want %s", during_redirect, i, fmt(obs), fmt(exp));
            else passed++;
            tick();
        end
    endtask

    // Two redirects in a row, a stall while empty, then a redirect to the current PC.
    task automatic test_back_to_back();
        obs_t want [7];
        bit   s_in [7];
        bit   r_in [7];
        logic [31:0] t_in [7];
        want[0] = pack(32'h3,  32'h3,  32'h0,    1'b0, 1'b1); s_in[0] = 0; r_in[0] = 1; t_in[0] = 32'h10;
        want[1] = pack(32'h10, 32'h4,  32'h0,    1'b0, 1'b1); s_in[1] = 0; r_in[1] = 1; t_in[1] = 32'h20;
        want[2] = pack(32'h10, 32'h11, 32'h0,    1'b0, 1'b0); s_in[2] = 1; r_in[2] = 0; t_in[2] = 32'h0;
        want[3] = pack(32'h20, 32'h11, 32'h0,    1'b0, 1'b1); s_in[3] = 0; r_in[3] = 0; t_in[3] = 32'h0;
        want[4] = pack(32'h21, 32'h21, 32'h1020, 1'b1, 1'b1); s_in[4] = 0; r_in[4] = 0; t_in[4] = 32'h0;
        want[5] = pack(32'h22, 32'h22, 32'h0,    1'b0, 1'b1); s_in[5] = 0; r_in[5] = 1; t_in[5] = 32'h22;
        want[6] = pack(32'h22, 32'h23, 32'h0,    1'b0, 1'b1); s_in[6] = 0; r_in[6] = 0; t_in[6] = 32'h0;
        for (int i = 0; i < 7; i++) begin
            apply(0, s_in[i], r_in[i], t_in[i]);
            checks++;
            if (obs !== want[i]) $display("FAIL back_to_back[%0d]: got %s want %s", i, fmt(obs), fmt(want[i]));
            else passed++;
            tick();
        end
        apply(0, 0, 0, 32'h0);
        exp = pack(32'h23, 32'h23, 32'h1022, 1'b1, 1'b1);
        checks++;
        if (obs !== exp) $display("FAIL self_redirect_target: got %s want %s", fmt(obs), fmt(exp));
        else passed++;
        tick();
    endtask

    // Model: next_addr is the next fetch to issue, shown_addr the fetch being
    // presented, shown_real whether that fetch survives (not squashed, not reset).
    task automatic test_random();
        logic [31:0] next_addr  = '0;
        logic [31:0] shown_addr = '0;
        bit          shown_real = 0;
        bit          known      = 0;
        for (int n = 0; n < 400; n++) begin
            bit          c;
            bit          s;
            bit          r;
            logic [31:0] t;
            c = (n == 0) || ($urandom_range(0, 49) == 0);
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 6) == 0);
            t = ($urandom_range(0, 1) == 1) ? 32'($urandom)
                                            : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
            apply(c, s, r, t);
            if (known) begin
                exp = pack((s && !r) ? shown_addr : next_addr,
                           shown_addr + 32'd1,
                           (shown_real && !r) ? mem_f(shown_addr) : 32'h0,
                           shown_real && !r,
                           !s || r);
                checks++;
                if (obs !== exp) $display("FAIL random[%0d]: got %s want %s", n, fmt(obs), fmt(exp));
                else passed++;
            end
            tick();
            if (c) begin
                next_addr  = '0;
                shown_addr = '0;
                shown_real = 0;
                known      = 1;
            end else if (r) begin
                shown_addr = next_addr;
                next_addr  = t;
                shown_real = 0;
            end else if (!s) begin
                shown_addr = next_addr;
                next_addr  = next_addr + 32'd1;
                shown_real = 1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_clr_mid(0);
        test_clr_mid(1);
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
